// File: rtl/layer2_feeder_pkg.sv
// rtl/layer2_feeder_pkg.sv - shared widths and state encoding for the layer-2 feeder
`timescale 1ns/1ps
package layer2_feeder_pkg;

    localparam int LAYER_2_IN_BIT_WIDTH      = 3;
    localparam int LAYER_2_WEIGHTS_BIT_WIDTH = 3;
    localparam int LAYER_2_OUT_BIT_WIDTH     = 16;
    localparam int LAYER_2_NUM_OUTPUTS       = 10;
    localparam int CLASS_W                   = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_SCAN   = 3'd4,
        S_RESULT = 3'd5
    } l2f_state_t;

endpackage

// File: rtl/layer2_feeder_argmax_scan.sv
// rtl/layer2_feeder_argmax_scan.sv - serial signed argmax over packed neuron sums
// One neuron per scan_en cycle; strict greater-than keeps the lowest index on ties.
`timescale 1ns/1ps
module l2_argmax_scan
    import layer2_feeder_pkg::*;
#(
    parameter int NUM_OUTPUTS = LAYER_2_NUM_OUTPUTS,
    parameter int OUT_W       = LAYER_2_OUT_BIT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         scan_en,
    input  logic [NUM_OUTPUTS*OUT_W-1:0] sums,
    output logic                         scan_done,
    output logic [CLASS_W-1:0]           max_idx,
    output logic signed [OUT_W-1:0]      max_val
);

    logic [CLASS_W-1:0]      idx;
    logic signed [OUT_W-1:0] cur;

    assign cur       = sums[int'(idx)*OUT_W +: OUT_W];
    assign scan_done = scan_en && (idx == CLASS_W'(NUM_OUTPUTS-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            max_idx <= '0;
            max_val <= '0;
        end else if (scan_en) begin
            // index 0 seeds the running max so no sentinel value is needed
            if ((idx == '0) || (cur > max_val)) begin
                max_idx <= idx;
                max_val <= cur;
            end
            idx <= scan_done ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/layer2_feeder.sv
// rtl/layer2_feeder.sv - feeds activation/weight-row pairs to multStore and returns the argmax class
`timescale 1ns/1ps
module layer2_feeder
    import layer2_feeder_pkg::*;
#(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_OUTPUTS = LAYER_2_NUM_OUTPUTS,
    parameter int IN_W        = LAYER_2_IN_BIT_WIDTH,
    parameter int WW          = LAYER_2_WEIGHTS_BIT_WIDTH,
    parameter int OUT_W       = LAYER_2_OUT_BIT_WIDTH,
    parameter int MULT_LAT    = 1
) (
    input  logic                             clk,
    input  logic                             clr_n,
    input  logic                             start,
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_W-1:0]                  in_data,
    output logic [$clog2(NUM_INPUTS)-1:0]    w_addr,
    input  logic [NUM_OUTPUTS*WW-1:0]        w_data,
    output logic [IN_W-1:0]                  layer2In,
    output logic [NUM_OUTPUTS*WW-1:0]        weightsIn,
    output logic                             acc_clr,
    output logic                             acc_en,
    input  logic [NUM_OUTPUTS*OUT_W-1:0]     sum_in,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [CLASS_W-1:0]               result_class,
    output logic [OUT_W-1:0]                 result_sum
);

    localparam int AW = $clog2(NUM_INPUTS);
    localparam int DW = $clog2(MULT_LAT + 2);

    l2f_state_t              state, state_nxt;
    logic [AW-1:0]           cnt;
    logic [DW-1:0]           dcnt;
    logic [IN_W-1:0]         l2_data;
    logic [NUM_OUTPUTS*WW-1:0] w_hold;
    logic                    accept, last_accept, drain_done;
    logic                    scan_en, scan_done;
    logic [CLASS_W-1:0]      max_idx;
    logic signed [OUT_W-1:0] max_val;

    assign accept      = (state == S_FEED) && in_valid;
    assign last_accept = accept && (cnt == AW'(NUM_INPUTS-1));
    assign drain_done  = (state == S_DRAIN) && (dcnt == DW'(MULT_LAT));

    // ROM row arrives the cycle after w_addr, aligned with the registered activation
    assign w_addr    = cnt;
    assign layer2In  = l2_data;
    assign weightsIn = acc_en ? w_data : w_hold;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = (state != S_IDLE);
        in_ready     = 1'b0;
        acc_clr      = 1'b0;
        scan_en      = 1'b0;
        result_valid = 1'b0;
        result_class = '0;
        result_sum   = '0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                acc_clr   = 1'b1;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                in_ready = 1'b1;
                if (last_accept) state_nxt = S_DRAIN;
            end
            S_DRAIN:  if (drain_done) state_nxt = S_SCAN;
            S_SCAN: begin
                scan_en = 1'b1;
                if (scan_done) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                result_valid = 1'b1;
                result_class = max_idx;
                result_sum   = max_val;
                if (result_ready) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt     <= '0;
            dcnt    <= '0;
            l2_data <= '0;
            w_hold  <= '0;
            acc_en  <= 1'b0;
        end else begin
            acc_en <= accept;
            if (accept) l2_data <= in_data;
            if (acc_en) w_hold <= w_data;
            if (state == S_CLEAR) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= last_accept ? '0 : cnt + 1'b1;
            end
            dcnt <= ((state == S_DRAIN) && !drain_done) ? dcnt + 1'b1 : '0;
        end
    end

    l2_argmax_scan #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .OUT_W       (OUT_W)
    ) u_scan (
        .clk       (clk),
        .rst_n     (clr_n),
        .scan_en   (scan_en),
        .sums      (sum_in),
        .scan_done (scan_done),
        .max_idx   (max_idx),
        .max_val   (max_val)
    );

endmodule

// File: tb/tb_layer2_feeder.sv
// tb/tb_layer2_feeder.sv - bench for layer2_feeder with weight ROM and multStore models
`timescale 1ns/1ps
module tb_layer2_feeder;

    localparam int NI    = 16;
    localparam int NO    = 10;
    localparam int IN_W  = 3;
    localparam int WW    = 3;
    localparam int OUT_W = 16;

    typedef struct { logic [IN_W-1:0] d; logic [NO*WW-1:0] w; } term_t;
    typedef struct { logic [3:0] cls; logic [OUT_W-1:0] sm; } res_t;

    logic                 clk = 1'b0;
    logic                 clr_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IN_W-1:0]      in_data = '0;
    logic [3:0]           w_addr;
    logic [NO*WW-1:0]     w_data = '0;
    logic [IN_W-1:0]      layer2In;
    logic [NO*WW-1:0]     weightsIn;
    logic                 acc_clr;
    logic                 acc_en;
    logic [NO*OUT_W-1:0]  sum_in;
    logic                 result_valid;
    logic                 result_ready = 1'b0;
    logic [3:0]           result_class;
    logic [OUT_W-1:0]     result_sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_first = -1;
    int acc_last = -1;

    logic [IN_W-1:0]         act [NI];
    logic [WW-1:0]           wt  [NI][NO];
    logic signed [OUT_W-1:0] msum [NO];
    term_t                   term_q [$];
    res_t                    exp_q  [$];

    layer2_feeder #(
        .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .IN_W(IN_W), .WW(WW), .OUT_W(OUT_W), .MULT_LAT(1)
    ) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data), .layer2In(layer2In), .weightsIn(weightsIn),
        .acc_clr(acc_clr), .acc_en(acc_en), .sum_in(sum_in),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_sum(result_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NO*WW-1:0] pack_row(input int r);
        logic [NO*WW-1:0] p;
        for (int i = 0; i < NO; i++) p[i*WW +: WW] = wt[r][i];
        return p;
    endfunction

    // weight ROM with one-cycle registered read
    always @(posedge clk) w_data <= pack_row(int'(w_addr));

    // multStore: sum_in reflects an acc_en term one cycle later
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NO; i++) msum[i] <= '0;
        end else if (acc_clr) begin
            for (int i = 0; i < NO; i++) msum[i] <= '0;
        end else if (acc_en) begin
            for (int i = 0; i < NO; i++)
                msum[i] <= msum[i] + OUT_W'(int'(layer2In) * int'($signed(weightsIn[i*WW +: WW])));
        end
    end

    always_comb begin
        sum_in = '0;
        for (int i = 0; i < NO; i++) sum_in[i*OUT_W +: OUT_W] = msum[i];
    end

    always @(negedge clk) begin
        term_t t;
        if (clr_n && acc_en) begin
            checks++;
            if (term_q.size() == 0) begin
                errors++;
                $display("FAIL term_unexpected layer2In=%h weightsIn=%h with no pending term", layer2In, weightsIn);
            end else begin
                t = term_q.pop_front();
                if ((layer2In !== t.d) || (weightsIn !== t.w)) begin
                    errors++;
                    $display("FAIL term layer2In=%h weightsIn=%h required %h %h", layer2In, weightsIn, t.d, t.w);
                end
            end
            acc_cnt++;
            if (acc_first < 0) acc_first = cyc;
            acc_last = cyc;
        end
    end

    function automatic void ref_argmax(output logic [3:0] c, output logic [OUT_W-1:0] s);
        int acc [NO];
        int best, bi;
        for (int i = 0; i < NO; i++) acc[i] = 0;
        for (int r = 0; r < NI; r++)
            for (int i = 0; i < NO; i++) acc[i] += int'(act[r]) * int'($signed(wt[r][i]));
        bi = 0;
        best = acc[0];
        for (int i = 1; i < NO; i++) if (acc[i] > best) begin best = acc[i]; bi = i; end
        c = 4'(bi);
        s = OUT_W'(best);
    endfunction

    task automatic set_basic();
        for (int r = 0; r < NI; r++) begin
            act[r] = 3'b001;
            for (int i = 0; i < NO; i++) wt[r][i] = 3'b001;
        end
    endtask

    task automatic set_tie();
        for (int r = 0; r < NI; r++) begin
            act[r] = (r < 5) ? 3'b001 : 3'b000;
            for (int i = 0; i < NO; i++)
                if (i == 3 || i == 7) wt[r][i] = 3'b001;
                else wt[r][i] = (r < 2) ? 3'b111 : 3'b000;
        end
    endtask

    task automatic set_negative();
        for (int r = 0; r < NI; r++) begin
            act[r] = (r < 3) ? 3'b001 : 3'b000;
            for (int i = 0; i < NO; i++)
                if (i == 6) wt[r][i] = (r == 0) ? 3'b111 : 3'b000;
                else wt[r][i] = 3'b111;
        end
    endtask

    task automatic set_random();
        for (int r = 0; r < NI; r++) begin
            act[r] = 3'($urandom_range(0, 7));
            for (int i = 0; i < NO; i++) wt[r][i] = 3'($urandom_range(0, 7));
        end
    endtask

    // caller is #1 after a rising edge with the DUT idle
    task automatic do_frame(input int stall_after, input int stall_len,
                            output int lat, output bit saw_clr, output bit ok);
        int k, gap, guard, t0;
        acc_cnt = 0; acc_first = -1; acc_last = -1;
        k = 0; gap = 0; guard = 0;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        saw_clr = acc_clr;
        while (k < NI && guard < 200) begin
            if (k == stall_after && gap < stall_len) begin
                in_valid = 1'b0;
                gap++;
            end else begin
                in_valid = 1'b1;
                in_data  = act[k];
            end
            if (in_valid && in_ready) begin
                term_q.push_back('{d: act[k], w: pack_row(k)});
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        guard = 0;
        while (!result_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        ok  = result_valid;
        lat = cyc - t0;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input bit ok);
        res_t e;
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout result_valid=%b required 1", name, result_valid);
        end else if ((result_class !== e.cls) || (result_sum !== e.sm)) begin
            errors++;
            $display("FAIL %s_result class=%0d sum=%0d required class=%0d sum=%0d",
                     name, result_class, $signed(result_sum), e.cls, $signed(e.sm));
        end
    endtask

    task automatic test_reset();
        int k, guard, lat, seen;
        bit clr, ok;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, in_ready, acc_clr, acc_en, result_valid, w_addr, layer2In, weightsIn, result_class, result_sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b in_ready=%b acc_en=%b w_addr=%h weightsIn=%h required all 0",
                     busy, in_ready, acc_en, w_addr, weightsIn);
        end
        clr_n = 1'b1;
        @(posedge clk); #1;
        set_basic();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; guard = 0;
        while (k < 5 && guard < 50) begin
            in_valid = 1'b1;
            in_data  = act[k];
            if (in_ready) begin
                term_q.push_back('{d: act[k], w: pack_row(k)});
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        clr_n = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, acc_clr, acc_en, result_valid, w_addr, layer2In, weightsIn, result_class, result_sum} !== '0) begin
            errors++;
            $display("FAIL midfeed_reset busy=%b in_ready=%b acc_en=%b w_addr=%h layer2In=%h weightsIn=%h required all 0",
                     busy, in_ready, acc_en, w_addr, layer2In, weightsIn);
        end
        term_q.delete();
        @(posedge clk); #1;
        clr_n = 1'b1;
        seen = 0;
        repeat (40) begin
            if (result_valid || busy) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_result active_cycles=%0d required 0", seen);
        end
        exp_q.push_back('{cls: 4'd0, sm: 16'd16});
        do_frame(-1, 0, lat, clr, ok);
        check_result("after_reset", ok);
        handshake();
    endtask

    task automatic test_basic();
        int lat;
        bit clr, ok;
        set_basic();
        exp_q.push_back('{cls: 4'd0, sm: 16'd16});
        do_frame(-1, 0, lat, clr, ok);
        check_result("basic", ok);
        checks++;
        if (lat !== 30) begin
            errors++;
            $display("FAIL basic_latency cycles=%0d required 30", lat);
        end
        checks++;
        if (acc_cnt !== 16 || (acc_last - acc_first + 1) !== 16) begin
            errors++;
            $display("FAIL basic_acc_en count=%0d span=%0d required 16 16", acc_cnt, acc_last - acc_first + 1);
        end
        checks++;
        if (term_q.size() !== 0) begin
            errors++;
            $display("FAIL basic_terms_left pending=%0d required 0", term_q.size());
        end
        handshake();
    endtask

    task automatic test_stall();
        int lat;
        bit clr, ok;
        set_basic();
        exp_q.push_back('{cls: 4'd0, sm: 16'd16});
        do_frame(4, 3, lat, clr, ok);
        check_result("stall", ok);
        checks++;
        if (acc_cnt !== 16 || (acc_last - acc_first + 1 - acc_cnt) !== 3) begin
            errors++;
            $display("FAIL stall_acc_en count=%0d gaps=%0d required 16 3", acc_cnt, acc_last - acc_first + 1 - acc_cnt);
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL stall_latency cycles=%0d required 33", lat);
        end
        handshake();
    endtask

    task automatic test_tie_and_negative();
        int lat;
        bit clr, ok;
        set_tie();
        exp_q.push_back('{cls: 4'd3, sm: 16'd5});
        do_frame(-1, 0, lat, clr, ok);
        check_result("tie", ok);
        handshake();
        set_negative();
        exp_q.push_back('{cls: 4'd6, sm: 16'hFFFF});
        do_frame(-1, 0, lat, clr, ok);
        check_result("negative", ok);
        handshake();
    endtask

    task automatic test_hold();
        int lat, bad;
        bit clr, ok;
        set_basic();
        exp_q.push_back('{cls: 4'd0, sm: 16'd16});
        do_frame(-1, 0, lat, clr, ok);
        check_result("hold", ok);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!result_valid || !busy || acc_clr || result_class !== 4'd0 || result_sum !== 16'd16) bad++;
            start = (i % 3 == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable bad_cycles=%0d required 0", bad);
        end
        handshake();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release busy=%b result_valid=%b required 0 0", busy, result_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit clr, ok;
        logic [3:0] c;
        logic [OUT_W-1:0] s;
        set_basic();
        exp_q.push_back('{cls: 4'd0, sm: 16'd16});
        do_frame(-1, 0, lat, clr, ok);
        check_result("b2b_first", ok);
        set_random();
        ref_argmax(c, s);
        exp_q.push_back('{cls: c, sm: s});
        handshake();
        do_frame(-1, 0, lat, clr, ok);
        checks++;
        if (clr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_acc_clr acc_clr=%b required 1", clr);
        end
        check_result("b2b_second", ok);
        handshake();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_tie_and_negative();
        test_hold();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
